mem_access_fsm: RTL and testbench

//  Multi-cycle MEM-stage load/store unit; successor to the combinational MEM stage and its cnt handshake.

---
 rtl/mem_access_fsm_if.sv | 24 ++
 rtl/mem_access_fsm.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_mem_access_fsm.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_fsm_if.sv
// Memory bus between the MEM-stage load/store FSM (master) and the memory
// system (slave). The master holds ce/we/sel/addr/data stable until the slave
// returns a one-cycle mem_ready_i pulse with the read data.
interface mem_access_fsm_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_ce_o;
  logic              mem_we_o;
  logic [3:0]        mem_sel_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;
  logic [31:0]       mem_data_i;
  logic              mem_ready_i;

  modport master (
    output mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ready_i
  );

  modport slave (
    input  mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ready_i
  );
endinterface

// File: rtl/mem_access_fsm.sv
// Multi-cycle MEM-stage load/store unit (IDLE -> ACCESS -> RESP).
// The request is latched on accept and the bus signals are registered and held
// until mem_ready_i or a bus timeout. Non-memory ops pass through in IDLE with
// zero latency. Little-endian byte lanes: byte k = bits[8k+7:8k], sel bit k.
// Optional feature: define MEM_ALIGN_EXC_EN to raise address-error exceptions
// for misaligned halfword/word accesses instead of silently aligning them.
module mem_access_fsm #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 12,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  input  logic        llbit_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq,
  output logic        llbit_we_o,
  output logic        llbit_value_o,
  mem_access_fsm_if.master bus,
  output logic        excp_adel_o,
  output logic        excp_ades_o,
  output logic        excp_bus_o
);

  // EX/MEM load/store opcodes
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LWL = 8'b1110_0010;
  localparam logic [7:0] OP_LWR = 8'b1110_0110;
  localparam logic [7:0] OP_LL  = 8'b1111_0000;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_SWL = 8'b1110_1010;
  localparam logic [7:0] OP_SWR = 8'b1110_1110;
  localparam logic [7:0] OP_SC  = 8'b1111_1000;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [7:0]        lat_op;
  logic [1:0]        lat_a;
  logic [31:0]       lat_reg2;
  logic [4:0]        lat_wd;
  logic              lat_wreg;
  logic              lat_flush;
  logic              lat_err;
  logic [31:0]       resp_wdata;

  logic              is_load;
  logic              is_store;
  logic              sc_fail;
  logic              adel;
  logic              ades;
  logic              accept;
  logic [ADDR_W-1:0] bus_addr;

  // Byte-enable pattern for the access
  function automatic logic [3:0] f_sel(input logic [7:0] op, input logic [1:0] a);
    case (op)
      OP_LB, OP_LBU, OP_SB: f_sel = 4'b0001 << a;
      OP_LH, OP_LHU, OP_SH: f_sel = a[1] ? 4'b1100 : 4'b0011;
      OP_SWL: case (a)
                2'd0:    f_sel = 4'b0001;
                2'd1:    f_sel = 4'b0011;
                2'd2:    f_sel = 4'b0111;
                default: f_sel = 4'b1111;
              endcase
      OP_SWR: case (a)
                2'd0:    f_sel = 4'b1111;
                2'd1:    f_sel = 4'b1110;
                2'd2:    f_sel = 4'b1100;
                default: f_sel = 4'b1000;
              endcase
      default: f_sel = 4'b1111;
    endcase
  endfunction

  // Store data placed on the lanes selected by f_sel
  function automatic logic [31:0] f_wdata(input logic [7:0] op, input logic [1:0] a,
                                          input logic [31:0] r);
    case (op)
      OP_SB: f_wdata = {4{r[7:0]}};
      OP_SH: f_wdata = {2{r[15:0]}};
      OP_SWL: case (a)
                2'd0:    f_wdata = {24'd0, r[31:24]};
                2'd1:    f_wdata = {16'd0, r[31:16]};
                2'd2:    f_wdata = {8'd0, r[31:8]};
                default: f_wdata = r;
              endcase
      OP_SWR: case (a)
                2'd0:    f_wdata = r;
                2'd1:    f_wdata = {r[23:0], 8'd0};
                2'd2:    f_wdata = {r[15:0], 16'd0};
                default: f_wdata = {r[7:0], 24'd0};
              endcase
      default: f_wdata = r;
    endcase
  endfunction

  // Write-back value: lane extraction, LWL/LWR merge, SC success flag
  function automatic logic [31:0] f_load(input logic [7:0] op, input logic [1:0] a,
                                         input logic [31:0] w, input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:  f_load = {{24{b[7]}}, b};
      OP_LBU: f_load = {24'd0, b};
      OP_LH:  f_load = {{16{h[15]}}, h};
      OP_LHU: f_load = {16'd0, h};
      OP_LW, OP_LL: f_load = w;
      OP_LWL: case (a)
                2'd0:    f_load = {w[7:0], r[23:0]};
                2'd1:    f_load = {w[15:0], r[15:0]};
                2'd2:    f_load = {w[23:0], r[7:0]};
                default: f_load = w;
              endcase
      OP_LWR: case (a)
                2'd0:    f_load = w;
                2'd1:    f_load = {r[31:24], w[31:8]};
                2'd2:    f_load = {r[31:16], w[31:16]};
                default: f_load = {r[31:8], w[31:24]};
              endcase
      OP_SC:  f_load = 32'd1;
      default: f_load = 32'd0;
    endcase
  endfunction

  // Decode the incoming op and decide whether IDLE accepts it
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    bus_addr = {mem_addr_i[ADDR_W-1:2], 2'b00};
    case (aluop_i)
      OP_LB, OP_LBU, OP_LH, OP_LHU: begin
        is_load  = 1'b1;
        bus_addr = mem_addr_i[ADDR_W-1:0];
      end
      OP_LW, OP_LWL, OP_LWR, OP_LL: is_load = 1'b1;
      OP_SB, OP_SH: begin
        is_store = 1'b1;
        bus_addr = mem_addr_i[ADDR_W-1:0];
      end
      OP_SW, OP_SWL, OP_SWR, OP_SC: is_store = 1'b1;
      default: begin
        is_load  = 1'b0;
        is_store = 1'b0;
      end
    endcase
    sc_fail = (aluop_i == OP_SC) && !llbit_i;
`ifdef MEM_ALIGN_EXC_EN
    adel = (((aluop_i == OP_LH) || (aluop_i == OP_LHU)) && mem_addr_i[0]) ||
           (((aluop_i == OP_LW) || (aluop_i == OP_LL)) && (mem_addr_i[1:0] != 2'b00));
    ades = ((aluop_i == OP_SH) && mem_addr_i[0]) ||
           (((aluop_i == OP_SW) || (aluop_i == OP_SC)) && (mem_addr_i[1:0] != 2'b00));
`else
    adel = 1'b0;
    ades = 1'b0;
`endif
    accept = (state == IDLE) && (is_load || is_store) && !flush_i && !sc_fail && !adel && !ades;
  end

  // Bus FSM: latch request, drive registered bus, count timeout, capture result
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      count          <= '0;
      lat_op         <= 8'd0;
      lat_a          <= 2'd0;
      lat_reg2       <= 32'd0;
      lat_wd         <= 5'd0;
      lat_wreg       <= 1'b0;
      lat_flush      <= 1'b0;
      lat_err        <= 1'b0;
      resp_wdata     <= 32'd0;
      bus.mem_ce_o   <= 1'b0;
      bus.mem_we_o   <= 1'b0;
      bus.mem_sel_o  <= 4'b0000;
      bus.mem_addr_o <= '0;
      bus.mem_data_o <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state          <= ACCESS;
            count          <= '0;
            lat_op         <= aluop_i;
            lat_a          <= mem_addr_i[1:0];
            lat_reg2       <= reg2_i;
            lat_wd         <= wd_i;
            lat_wreg       <= wreg_i;
            lat_flush      <= 1'b0;
            lat_err        <= 1'b0;
            bus.mem_ce_o   <= 1'b1;
            bus.mem_we_o   <= is_store;
            bus.mem_sel_o  <= f_sel(aluop_i, mem_addr_i[1:0]);
            bus.mem_addr_o <= bus_addr;
            bus.mem_data_o <= f_wdata(aluop_i, mem_addr_i[1:0], reg2_i);
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          // A flush never abandons the transfer; it only mutes the response
          lat_flush <= lat_flush | flush_i;
          if (bus.mem_ready_i) begin
            resp_wdata    <= f_load(lat_op, lat_a, bus.mem_data_i, lat_reg2);
            state         <= RESP;
            bus.mem_ce_o  <= 1'b0;
            bus.mem_we_o  <= 1'b0;
            bus.mem_sel_o <= 4'b0000;
          end else if (count == CNT_W'(TIMEOUT - 1)) begin
            lat_err       <= 1'b1;
            state         <= RESP;
            bus.mem_ce_o  <= 1'b0;
            bus.mem_we_o  <= 1'b0;
            bus.mem_sel_o <= 4'b0000;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Result / stall / exception outputs: IDLE passthrough, RESP from latches
  always_comb begin
    wd_o          = 5'd0;
    wreg_o        = 1'b0;
    wdata_o       = 32'd0;
    stallreq      = 1'b0;
    llbit_we_o    = 1'b0;
    llbit_value_o = 1'b0;
    excp_adel_o   = 1'b0;
    excp_ades_o   = 1'b0;
    excp_bus_o    = 1'b0;
    if (rst) begin
      stallreq = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wd_o    = wd_i;
          wdata_o = wdata_i;
          if (flush_i) begin
            wreg_o = 1'b0;
          end else if (adel || ades) begin
            excp_adel_o = adel;
            excp_ades_o = ades;
          end else if (sc_fail) begin
            wdata_o = 32'd0;
            wreg_o  = wreg_i;
          end else if (is_load || is_store) begin
            stallreq = 1'b1;
          end else begin
            wreg_o = wreg_i;
          end
        end
        ACCESS: begin
          wd_o     = lat_wd;
          stallreq = 1'b1;
        end
        RESP: begin
          wd_o    = lat_wd;
          wdata_o = resp_wdata;
          if (lat_err) begin
            excp_bus_o = !lat_flush;
          end else if (lat_flush || flush_i) begin
            wreg_o = 1'b0;
          end else begin
            case (lat_op)
              OP_LL: begin
                wreg_o        = lat_wreg;
                llbit_we_o    = 1'b1;
                llbit_value_o = 1'b1;
              end
              OP_SC: begin
                wreg_o     = 1'b1;
                llbit_we_o = 1'b1;
              end
              OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR: wreg_o = lat_wreg;
              default: wreg_o = 1'b0;
            endcase
          end
        end
        default: stallreq = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_fsm.sv
// Directed bench for mem_access_fsm: the bench plays the memory slave by hand,
// drives inputs just after the falling edge and samples outputs 1 ns later.
module tb_mem_access_fsm;
  localparam logic [7:0] OP_NOP = 8'b0010_0000;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LWR = 8'b1110_0110;
  localparam logic [7:0] OP_LL  = 8'b1111_0000;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_SWL = 8'b1110_1010;
  localparam logic [7:0] OP_SC  = 8'b1111_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [31:0] mem_addr, reg2, wdata;
  logic [4:0]  wd;
  logic        wreg, flush, llbit;
  logic [4:0]  wd_o;
  logic        wreg_o, stallreq, llbit_we_o, llbit_value_o;
  logic [31:0] wdata_o;
  logic        excp_adel_o, excp_ades_o, excp_bus_o;
  int          n_vec = 0;
  int          n_bad = 0;
  int          ce_cycles;

  mem_access_fsm_if #(.ADDR_W(32)) bus ();

  mem_access_fsm #(.ADDR_W(32), .TIMEOUT(12), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .mem_addr_i(mem_addr), .reg2_i(reg2),
    .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata), .flush_i(flush), .llbit_i(llbit),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq(stallreq),
    .llbit_we_o(llbit_we_o), .llbit_value_o(llbit_value_o), .bus(bus),
    .excp_adel_o(excp_adel_o), .excp_ades_o(excp_ades_o), .excp_bus_o(excp_bus_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic nop_inputs();
    aluop = OP_NOP; mem_addr = 32'd0; reg2 = 32'd0; wd = 5'd0; wreg = 1'b0;
    wdata = 32'd0; flush = 1'b0; llbit = 1'b0;
  endtask

  // One complete access: accept, `waits` ACCESS cycles without ready, ready, RESP
  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] r2, input logic [31:0] word, input int waits,
                        input logic [3:0] esel, input logic [31:0] edata, input logic ewe,
                        input logic [31:0] eaddr, input logic [31:0] ewdata, input logic ewreg,
                        input logic ellw, input logic ellv);
    @(negedge clk);
    aluop = op; mem_addr = addr; reg2 = r2; wd = 5'd9; wreg = 1'b1; llbit = 1'b1;
    #1;
    chk({tag, "_t0_stall"}, stallreq, 1'b1);
    chk({tag, "_t0_wreg"}, wreg_o, 1'b0);
    @(negedge clk);
    nop_inputs();
    for (int i = 0; i < waits; i++) begin
      #1;
      chk({tag, "_hold_sel"}, bus.mem_sel_o, esel);
      @(negedge clk);
    end
    bus.mem_ready_i = 1'b1; bus.mem_data_i = word;
    #1;
    chk({tag, "_ce"}, bus.mem_ce_o, 1'b1);
    chk({tag, "_we"}, bus.mem_we_o, ewe);
    chk({tag, "_sel"}, bus.mem_sel_o, esel);
    chk({tag, "_addr"}, bus.mem_addr_o, eaddr);
    chk({tag, "_acc_stall"}, stallreq, 1'b1);
    if (ewe) chk({tag, "_wdat"}, bus.mem_data_o, edata);
    @(negedge clk);
    bus.mem_ready_i = 1'b0; bus.mem_data_i = 32'd0;
    #1;
    chk({tag, "_resp_stall"}, stallreq, 1'b0);
    chk({tag, "_resp_ce"}, bus.mem_ce_o, 1'b0);
    chk({tag, "_resp_wreg"}, wreg_o, ewreg);
    chk({tag, "_resp_wd"}, wd_o, 5'd9);
    chk({tag, "_llwe"}, llbit_we_o, ellw);
    if (ellw) chk({tag, "_llval"}, llbit_value_o, ellv);
    if (ewreg) chk({tag, "_result"}, wdata_o, ewdata);
  endtask

  initial begin
    nop_inputs();
    bus.mem_ready_i = 1'b0; bus.mem_data_i = 32'd0;
    rst = 1'b1;
    wreg = 1'b1; wd = 5'd4; wdata = 32'h1111_2222;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_wreg", wreg_o, 1'b0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_stall", stallreq, 1'b0);
    chk("rst_ce", bus.mem_ce_o, 1'b0);
    chk("rst_sel", bus.mem_sel_o, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    wd = 5'd3; wreg = 1'b1; wdata = 32'h1234_5678;
    #1;
    chk("pass_wd", wd_o, 5'd3);
    chk("pass_wreg", wreg_o, 1'b1);
    chk("pass_wdata", wdata_o, 32'h1234_5678);
    chk("pass_stall", stallreq, 1'b0);
    @(negedge clk);
    nop_inputs();
    #1 chk("pass_ce", bus.mem_ce_o, 1'b0);

    run_op("lw",  OP_LW,  32'h100, 32'd0, 32'hDEAD_BEEF, 0, 4'b1111, 32'd0, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    run_op("lb",  OP_LB,  32'h103, 32'd0, 32'h80FF_1234, 2, 4'b1000, 32'd0, 1'b0, 32'h103, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0);
    run_op("lbu", OP_LBU, 32'h102, 32'd0, 32'h80FF_1234, 0, 4'b0100, 32'd0, 1'b0, 32'h102, 32'h0000_00FF, 1'b1, 1'b0, 1'b0);
    run_op("sb",  OP_SB,  32'h101, 32'hAB, 32'd0, 0, 4'b0010, 32'hABAB_ABAB, 1'b1, 32'h101, 32'd0, 1'b0, 1'b0, 1'b0);
    run_op("lh",  OP_LH,  32'h106, 32'd0, 32'h8001_7FFF, 1, 4'b1100, 32'd0, 1'b0, 32'h106, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0);
    run_op("lwr", OP_LWR, 32'h501, 32'hAABB_CCDD, 32'h1122_3344, 0, 4'b1111, 32'd0, 1'b0, 32'h500, 32'hAA11_2233, 1'b1, 1'b0, 1'b0);
    run_op("swl", OP_SWL, 32'h502, 32'hAABB_CCDD, 32'd0, 0, 4'b0111, 32'h00AA_BBCC, 1'b1, 32'h500, 32'd0, 1'b0, 1'b0, 1'b0);
    run_op("ll",  OP_LL,  32'h300, 32'd0, 32'h1122_3344, 0, 4'b1111, 32'd0, 1'b0, 32'h300, 32'h1122_3344, 1'b1, 1'b1, 1'b1);
    run_op("sc",  OP_SC,  32'h300, 32'h55, 32'd0, 0, 4'b1111, 32'h0000_0055, 1'b1, 32'h300, 32'd1, 1'b1, 1'b1, 1'b0);

    // SC with LL bit clear: no bus access, result 0, no stall
    @(negedge clk);
    aluop = OP_SC; mem_addr = 32'h300; reg2 = 32'h55; wd = 5'd2; wreg = 1'b1; llbit = 1'b0;
    #1;
    chk("scf_wdata", wdata_o, 32'd0);
    chk("scf_wreg", wreg_o, 1'b1);
    chk("scf_stall", stallreq, 1'b0);
    @(negedge clk);
    nop_inputs();
    #1 chk("scf_ce", bus.mem_ce_o, 1'b0);

    // Bus timeout: 12 ACCESS cycles without ready, then error response
    aluop = OP_LW; mem_addr = 32'h200; wd = 5'd9; wreg = 1'b1;
    @(negedge clk);
    nop_inputs();
    ce_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      #1 if (bus.mem_ce_o) ce_cycles++;
      @(negedge clk);
    end
    #1;
    chk("to_ce_cycles", ce_cycles, 12);
    chk("to_ce_drop", bus.mem_ce_o, 1'b0);
    chk("to_excp", excp_bus_o, 1'b1);
    chk("to_wreg", wreg_o, 1'b0);
    chk("to_stall", stallreq, 1'b0);
    @(negedge clk);
    #1 chk("to_pulse", excp_bus_o, 1'b0);

    // Flush while a store is in flight: the write still completes, no write-back
    aluop = OP_SW; mem_addr = 32'h400; reg2 = 32'hCAFE_F00D; wd = 5'd8; wreg = 1'b1;
    @(negedge clk);
    nop_inputs(); flush = 1'b1;
    #1 chk("fsw_ce", bus.mem_ce_o, 1'b1);
    @(negedge clk);
    flush = 1'b0; bus.mem_ready_i = 1'b1;
    #1;
    chk("fsw_ce2", bus.mem_ce_o, 1'b1);
    chk("fsw_we", bus.mem_we_o, 1'b1);
    chk("fsw_data", bus.mem_data_o, 32'hCAFE_F00D);
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    #1 chk("fsw_wreg", wreg_o, 1'b0);

    // Flush while LL in flight: response muted
    @(negedge clk);
    aluop = OP_LL; mem_addr = 32'h310; wd = 5'd7; wreg = 1'b1;
    @(negedge clk);
    nop_inputs(); flush = 1'b1;
    #1 chk("fll_ce", bus.mem_ce_o, 1'b1);
    @(negedge clk);
    flush = 1'b0; bus.mem_ready_i = 1'b1; bus.mem_data_i = 32'h7777_7777;
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    #1;
    chk("fll_wreg", wreg_o, 1'b0);
    chk("fll_llwe", llbit_we_o, 1'b0);

    // Flush arriving in RESP of a load
    @(negedge clk);
    aluop = OP_LW; mem_addr = 32'h120; wd = 5'd7; wreg = 1'b1;
    @(negedge clk);
    nop_inputs(); bus.mem_ready_i = 1'b1; bus.mem_data_i = 32'h0BAD_0BAD;
    @(negedge clk);
    bus.mem_ready_i = 1'b0; flush = 1'b1;
    #1 chk("frsp_wreg", wreg_o, 1'b0);

    // Flush in IDLE: memory op is not accepted
    @(negedge clk);
    aluop = OP_LW; mem_addr = 32'h140; wd = 5'd7; wreg = 1'b1; flush = 1'b1;
    #1;
    chk("fidle_stall", stallreq, 1'b0);
    chk("fidle_wreg", wreg_o, 1'b0);
    @(negedge clk);
    nop_inputs();
    #1 chk("fidle_ce", bus.mem_ce_o, 1'b0);

    // Reset in the middle of ACCESS, then a stray ready in IDLE
    aluop = OP_LW; mem_addr = 32'h180; wd = 5'd7; wreg = 1'b1;
    @(negedge clk);
    nop_inputs(); rst = 1'b1;
    #1 chk("rmid_ce_before", bus.mem_ce_o, 1'b1);
    @(negedge clk);
    rst = 1'b0; bus.mem_ready_i = 1'b1; bus.mem_data_i = 32'h5555_5555;
    #1;
    chk("rmid_ce", bus.mem_ce_o, 1'b0);
    chk("rmid_stall", stallreq, 1'b0);
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    #1;
    chk("stray_ready_wreg", wreg_o, 1'b0);
    chk("stray_ready_ce", bus.mem_ce_o, 1'b0);

`ifdef MEM_ALIGN_EXC_EN
    // Misaligned SW / LH raise address exceptions and never touch the bus
    aluop = OP_SW; mem_addr = 32'h102; reg2 = 32'h1234_5678; wd = 5'd7; wreg = 1'b1;
    #1;
    chk("ades", excp_ades_o, 1'b1);
    chk("ades_stall", stallreq, 1'b0);
    chk("ades_wreg", wreg_o, 1'b0);
    @(negedge clk);
    aluop = OP_LH; mem_addr = 32'h105;
    #1;
    chk("ades_ce", bus.mem_ce_o, 1'b0);
    chk("adel", excp_adel_o, 1'b1);
    @(negedge clk);
    nop_inputs();
    #1 chk("adel_ce", bus.mem_ce_o, 1'b0);
`else
    // Without alignment exceptions a misaligned SW writes the aligned word
    run_op("sw_mis", OP_SW, 32'h102, 32'h1234_5678, 32'd0, 0, 4'b1111, 32'h1234_5678, 1'b1, 32'h100, 32'd0, 1'b0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
